// File: rtl/zet_front_fetch_fifo.sv
// Instruction fetch FIFO between the prefetch wishbone master and decode.
// Stores {data, cs, ip} per fetched word and shows the head entry first-word-fall-through.
module zet_front_fetch_fifo #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush,
  input  logic          wr_fetch_fifo,
  input  logic [15:0]   fetch_dat_i,
  input  logic [15:0]   fifo_cs_i,
  input  logic [15:0]   fifo_ip_i,
  output logic          fifo_full,
  input  logic          rd_fetch_fifo,
  output logic          fifo_empty,
  output logic [15:0]   fetch_dat_o,
  output logic [15:0]   fifo_cs_o,
  output logic [15:0]   fifo_ip_o,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH - FULL_MARGIN);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]   dat_mem [DEPTH];
  logic [15:0]   cs_mem  [DEPTH];
  logic [15:0]   ip_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf_q;

  logic          pop_ok;
  logic          push_ok;
  logic          push_drop;

  // A push at full is still taken when a pop frees a slot the same cycle;
  // at empty the pop is ignored, so there is no same-cycle bypass.
  assign pop_ok    = rd_fetch_fifo && (count != '0) && !flush;
  assign push_ok   = wr_fetch_fifo && !flush && ((count != DEPTH_C) || pop_ok);
  assign push_drop = wr_fetch_fifo && !flush && !push_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the empty flag masks
  // stale contents, and a resettable array would cost a register per bit.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      dat_mem[wr_ptr] <= fetch_dat_i;
      cs_mem[wr_ptr]  <= fifo_cs_i;
      ip_mem[wr_ptr]  <= fifo_ip_i;
    end
  end

  // Status depends on the count register only, never on this cycle's strobes.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count >= FULL_LVL);
  assign fifo_count = count;
  assign overflow   = ovf_q;

  assign fetch_dat_o = fifo_empty ? 16'h0000 : dat_mem[rd_ptr];
  assign fifo_cs_o   = fifo_empty ? 16'h0000 : cs_mem[rd_ptr];
  assign fifo_ip_o   = fifo_empty ? 16'h0000 : ip_mem[rd_ptr];

endmodule

// File: tb/tb_zet_front_fetch_fifo.sv
// Bench for zet_front_fetch_fifo: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_zet_front_fetch_fifo;

  localparam int DEPTH       = 8;
  localparam int AW          = 3;
  localparam int FULL_MARGIN = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic        wr_fetch_fifo;
  logic [15:0] fetch_dat_i;
  logic [15:0] fifo_cs_i;
  logic [15:0] fifo_ip_i;
  logic        fifo_full;
  logic        rd_fetch_fifo;
  logic        fifo_empty;
  logic [15:0] fetch_dat_o;
  logic [15:0] fifo_cs_o;
  logic [15:0] fifo_ip_o;
  logic [AW:0] fifo_count;
  logic        overflow;

  zet_front_fetch_fifo #(.DEPTH(DEPTH), .AW(AW), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush         (flush),
    .wr_fetch_fifo (wr_fetch_fifo),
    .fetch_dat_i   (fetch_dat_i),
    .fifo_cs_i     (fifo_cs_i),
    .fifo_ip_i     (fifo_ip_i),
    .fifo_full     (fifo_full),
    .rd_fetch_fifo (rd_fetch_fifo),
    .fifo_empty    (fifo_empty),
    .fetch_dat_o   (fetch_dat_o),
    .fifo_cs_o     (fifo_cs_o),
    .fifo_ip_o     (fifo_ip_o),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {data, cs, ip} plus a sticky overflow bit.
  logic [47:0] mq[$];
  bit          m_ovf;

  task automatic model_apply(input bit wr, input bit rd, input bit fl,
                             input logic [15:0] d, input logic [15:0] c, input logic [15:0] i);
    bit popped;
    if (fl) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      popped = rd && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back({d, c, i});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [47:0] head;
    head = (mq.size() > 0) ? mq[0] : 48'h0;
    check({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
    check({tag, ".full"},  32'(fifo_full),  32'(mq.size() >= DEPTH - FULL_MARGIN));
    check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, ".dat"},   32'(fetch_dat_o), 32'(head[47:32]));
    check({tag, ".cs"},    32'(fifo_cs_o),   32'(head[31:16]));
    check({tag, ".ip"},    32'(fifo_ip_o),   32'(head[15:0]));
  endtask

  // One clock with the given strobes; outputs are settled 1 time unit later.
  task automatic step(input bit wr, input bit rd, input bit fl,
                      input logic [15:0] d, input logic [15:0] c, input logic [15:0] i);
    wr_fetch_fifo = wr;
    rd_fetch_fifo = rd;
    flush         = fl;
    fetch_dat_i   = d;
    fifo_cs_i     = c;
    fifo_ip_i     = i;
    @(posedge clk_i);
    #1;
    model_apply(wr, rd, fl, d, c, i);
    wr_fetch_fifo = 1'b0;
    rd_fetch_fifo = 1'b0;
    flush         = 1'b0;
  endtask

  typedef struct {
    bit          wr, rd, fl;
    logic [15:0] d, c, i;
    int          cnt;
    bit          emp, full, ovf;
    logic [15:0] hd, hc, hi;
  } vec_t;

  function automatic vec_t mk(bit wr, bit rd, bit fl, logic [15:0] d, logic [15:0] c, logic [15:0] i,
                              int cnt, bit emp, bit full, bit ovf,
                              logic [15:0] hd, logic [15:0] hc, logic [15:0] hi);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.c = c; v.i = i;
    v.cnt = cnt; v.emp = emp; v.full = full; v.ovf = ovf;
    v.hd = hd; v.hc = hc; v.hi = hi;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Directed table: expectations are written out from the intended behaviour.
    vecs.push_back(mk(1,0,0, 16'h1111, 16'hF000, 16'hFFF0, 1,0,0,0, 16'h1111, 16'hF000, 16'hFFF0));
    vecs.push_back(mk(1,0,0, 16'h2222, 16'hF000, 16'hFFF1, 2,0,0,0, 16'h1111, 16'hF000, 16'hFFF0));
    vecs.push_back(mk(1,0,0, 16'h3333, 16'hF000, 16'hFFF2, 3,0,0,0, 16'h1111, 16'hF000, 16'hFFF0));
    vecs.push_back(mk(0,1,0, 16'h0,    16'h0,    16'h0,    2,0,0,0, 16'h2222, 16'hF000, 16'hFFF1));
    vecs.push_back(mk(0,1,0, 16'h0,    16'h0,    16'h0,    1,0,0,0, 16'h3333, 16'hF000, 16'hFFF2));
    vecs.push_back(mk(0,1,0, 16'h0,    16'h0,    16'h0,    0,1,0,0, 16'h0,    16'h0,    16'h0));
    // Fill to DEPTH; full rises on the push that makes count 6.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1,0,0, 16'(16'h0100 + k), 16'h2000, 16'(16'h0010 + k),
                        k + 1, 0, (k + 1) >= 6, 0, 16'h0100, 16'h2000, 16'h0010));
    // Dropped push at full, then push+pop at full.
    vecs.push_back(mk(1,0,0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8,0,1,1, 16'h0100, 16'h2000, 16'h0010));
    vecs.push_back(mk(1,1,0, 16'hAAAA, 16'h2AAA, 16'hAAAA, 8,0,1,1, 16'h0101, 16'h2000, 16'h0011));
    // Drain: 0x0102..0x0107 then 0xAAAA as the eighth entry, then empty.
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6)
        vecs.push_back(mk(0,1,0, 16'h0, 16'h0, 16'h0, 8 - k, 0, (8 - k) >= 6, 1,
                          16'(16'h0101 + k), 16'h2000, 16'(16'h0011 + k)));
      else if (k == 7)
        vecs.push_back(mk(0,1,0, 16'h0, 16'h0, 16'h0, 1, 0, 0, 1, 16'hAAAA, 16'h2AAA, 16'hAAAA));
      else
        vecs.push_back(mk(0,1,0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0));
    end
    // Count 5, then flush with push and pop discards everything.
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,0,0, 16'(16'h0300 + k), 16'h3000, 16'(16'h0030 + k),
                        k + 1, 0, 0, 1, 16'h0300, 16'h3000, 16'h0030));
    vecs.push_back(mk(1,1,1, 16'h9999, 16'h9999, 16'h9999, 0,1,0,0, 16'h0, 16'h0, 16'h0));
    vecs.push_back(mk(1,0,0, 16'h5555, 16'h5000, 16'h5555, 1,0,0,0, 16'h5555, 16'h5000, 16'h5555));

    rst_ni        = 1'b0;
    flush         = 1'b0;
    wr_fetch_fifo = 1'b0;
    rd_fetch_fifo = 1'b0;
    fetch_dat_i   = '0;
    fifo_cs_i     = '0;
    fifo_ip_i     = '0;
    m_ovf         = 0;

    #12;
    check("rst.count", 32'(fifo_count), 0);
    check("rst.empty", 32'(fifo_empty), 1);
    check("rst.full",  32'(fifo_full),  0);
    check("rst.ovf",   32'(overflow),   0);
    check("rst.dat",   32'(fetch_dat_o), 0);
    check("rst.cs",    32'(fifo_cs_o),   0);
    check("rst.ip",    32'(fifo_ip_o),   0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    foreach (vecs[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      step(vecs[n].wr, vecs[n].rd, vecs[n].fl, vecs[n].d, vecs[n].c, vecs[n].i);
      check({tag, ".count"}, 32'(fifo_count),  32'(vecs[n].cnt));
      check({tag, ".empty"}, 32'(fifo_empty),  32'(vecs[n].emp));
      check({tag, ".full"},  32'(fifo_full),   32'(vecs[n].full));
      check({tag, ".ovf"},   32'(overflow),    32'(vecs[n].ovf));
      check({tag, ".dat"},   32'(fetch_dat_o), 32'(vecs[n].hd));
      check({tag, ".cs"},    32'(fifo_cs_o),   32'(vecs[n].hc));
      check({tag, ".ip"},    32'(fifo_ip_o),   32'(vecs[n].hi));
    end

    // Mid-stream asynchronous reset at count 4, asserted away from any edge.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 16'(16'h6000 + k), 16'h6000, 16'(k));
    check_model("pre_rst");
    check("pre_rst.count4", 32'(fifo_count), 4);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst.count", 32'(fifo_count), 0);
    check("arst.empty", 32'(fifo_empty), 1);
    check("arst.dat",   32'(fetch_dat_o), 0);
    check("arst.full",  32'(fifo_full),  0);
    mq.delete();
    m_ovf = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Continuous push/pop of 20 entries walks both pointers around twice.
    for (int n = 0; n <= 20; n++) begin
      step(n < 20, n > 0, 0, 16'(16'h7000 + n), 16'(16'h7100 + n), 16'(16'h7200 + n));
      check_model($sformatf("wrap%0d", n));
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bit wr, rd, fl;
      wr = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 59) == 0);
      step(wr, rd, fl, 16'($urandom), 16'($urandom), 16'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
